sublime_voice_scheduler: RTL

Produces the time-multiplexed per-voice stream that sublime_voice_mixer and the per-voice oscillator/envelope pipeline consume. Holds a voice table (note, velocity, gate) and allocates voices on note-on/note-off events. On each sample tick it walks every voice slot from NUM_VOICES-1 down to 0, so voice 0 always closes the sample frame.

---
 rtl/sublime_voice_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sublime_voice_scheduler.sv
// Voice table with note-on/off allocation and a per-sample frame walker that presents
// each voice slot (NUM_VOICES-1 down to 0) for VOICE_CYCLES clocks. Optional: SUBLIME_VOICE_STEAL_EN.
module sublime_voice_scheduler #(
  parameter int NUM_VOICES   = 8,
  parameter int VOICE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          note_on,
  input  logic                          note_off,
  input  logic [6:0]                    note,
  input  logic [7:0]                    velocity,
  output logic [$clog2(NUM_VOICES)-1:0] active_voice,
  output logic                          active_voice_changed,
  output logic [7:0]                    active_voice_velocity,
  output logic [6:0]                    active_voice_note,
  output logic                          active_voice_gate,
  output logic                          frame_busy,
  output logic                          overrun,
  output logic                          note_dropped
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int CW = (VOICE_CYCLES > 1) ? $clog2(VOICE_CYCLES) : 1;
  localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(VOICE_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NUM_VOICES-1:0] gate_tab;
  logic [6:0]      note_tab [NUM_VOICES];
  logic [7:0]      vel_tab  [NUM_VOICES];

  logic            hit;
  logic [VW-1:0]   hit_idx;
  logic            free;
  logic [VW-1:0]   free_idx;
  logic [VW-1:0]   next_voice;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_tab[i] && note_tab[i] == note) begin
        hit     = 1'b1;
        hit_idx = VW'(i);
      end
      if (!gate_tab[i]) begin
        free     = 1'b1;
        free_idx = VW'(i);
      end
    end
  end

  assign next_voice = active_voice - VW'(1);

  // Frame walker: active_voice doubles as the slot index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      active_voice          <= '0;
      active_voice_changed  <= 1'b0;
      active_voice_velocity <= '0;
      active_voice_note     <= '0;
      active_voice_gate     <= 1'b0;
      frame_busy            <= 1'b0;
      overrun               <= 1'b0;
    end else begin
      active_voice_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state                 <= RUN;
            cnt                   <= '0;
            frame_busy            <= 1'b1;
            active_voice          <= LAST_VOICE;
            active_voice_changed  <= 1'b1;
            active_voice_velocity <= vel_tab[LAST_VOICE];
            active_voice_note     <= note_tab[LAST_VOICE];
            active_voice_gate     <= gate_tab[LAST_VOICE];
          end
        end
        RUN: begin
          if (sample_tick) overrun <= 1'b1;
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (active_voice == '0) begin
              state      <= IDLE;
              frame_busy <= 1'b0;
            end else begin
              active_voice          <= next_voice;
              active_voice_changed  <= 1'b1;
              active_voice_velocity <= vel_tab[next_voice];
              active_voice_note     <= note_tab[next_voice];
              active_voice_gate     <= gate_tab[next_voice];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUBLIME_VOICE_STEAL_EN
  logic [VW-1:0] steal_ptr;
`endif

  // Voice table; note and note_off share one note bus, so note_on always wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_tab     <= '0;
      note_dropped <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_tab[i] <= '0;
        vel_tab[i]  <= '0;
      end
`ifdef SUBLIME_VOICE_STEAL_EN
      steal_ptr <= '0;
`endif
    end else begin
      note_dropped <= 1'b0;
      if (note_on) begin
        if (hit) begin
          vel_tab[hit_idx] <= velocity;
        end else if (free) begin
          note_tab[free_idx] <= note;
          vel_tab[free_idx]  <= velocity;
          gate_tab[free_idx] <= 1'b1;
        end else begin
`ifdef SUBLIME_VOICE_STEAL_EN
          note_tab[steal_ptr] <= note;
          vel_tab[steal_ptr]  <= velocity;
          gate_tab[steal_ptr] <= 1'b1;
          steal_ptr           <= steal_ptr + VW'(1);
`else
          note_dropped <= 1'b1;
`endif
        end
      end else if (note_off) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (gate_tab[i] && note_tab[i] == note) gate_tab[i] <= 1'b0;
        end
      end
    end
  end

endmodule
